stoch_bitgen3: RTL and testbench

Binary-to-stochastic converter for the stochastic LDPC decoder: it latches a binary probability word and emits a fixed-length burst of three independent stochastic bitstreams whose ones-density encodes that probability. It sits at the channel-input side of the decoder. It is the counterpart of the triple-stream up/down hard-decision counter at the output side, and its 3-bit output feeds that counter's 3-bit input directly in loopback tests.

---
 rtl/stoch_bitgen3_pkg.sv | 25 ++
 rtl/stoch_bitgen3_if.sv | 33 +++
 rtl/stoch_lfsr.sv | 36 +++
 rtl/stoch_bitgen3.sv | 114 +++++++++++
 tb/tb_stoch_bitgen3.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/stoch_bitgen3_pkg.sv
// ---------------------------------------------------------------------------
// stoch_pkg
// Shared definitions for the stochastic bit generator (stoch_bitgen3):
//   - state_t       : burst-controller FSM states (IDLE / RUN / DONE)
//   - LFSR_TAPS8    : feedback tap mask for the 8-bit x^8+x^6+x^5+x^4+1 LFSR
//   - SEEDx_DEF     : default nonzero seeds of the three stream LFSRs
// No ports; imported by stoch_lfsr and stoch_bitgen3.
// ---------------------------------------------------------------------------
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit i set means register bit i feeds the XOR: x^8->q[7], x^6->q[5],
    // x^5->q[4], x^4->q[3].
    localparam logic [7:0] LFSR_TAPS8 = 8'hB8;

    localparam logic [7:0] SEED0_DEF = 8'h01;
    localparam logic [7:0] SEED1_DEF = 8'h5A;
    localparam logic [7:0] SEED2_DEF = 8'hC3;

endpackage

// File: rtl/stoch_bitgen3_if.sv
// ---------------------------------------------------------------------------
// stoch_bitgen3_if
// Request / stream bundle of stoch_bitgen3.
//   LOAD    start request            (master -> slave)
//   ProbIN  probability word, Psize  (master -> slave)
//   Len     bits per stream, Lsize   (master -> slave)
//   BitOUT  three stochastic bits    (slave -> master)
//   VALID   BitOUT meaningful        (slave -> master)
//   BUSY    burst in progress        (slave -> master)
//   DONE    end-of-burst pulse       (slave -> master)
// ---------------------------------------------------------------------------
interface stoch_bitgen3_if #(
    parameter int Psize = 8,
    parameter int Lsize = 10
);
    logic             LOAD;
    logic [Psize-1:0] ProbIN;
    logic [Lsize-1:0] Len;
    logic [2:0]       BitOUT;
    logic             VALID;
    logic             BUSY;
    logic             DONE;

    modport master (
        output LOAD, ProbIN, Len,
        input  BitOUT, VALID, BUSY, DONE
    );

    modport slave (
        input  LOAD, ProbIN, Len,
        output BitOUT, VALID, BUSY, DONE
    );
endinterface

// File: rtl/stoch_lfsr.sv
// ---------------------------------------------------------------------------
// stoch_lfsr
// Maximal-length Fibonacci LFSR, shifting towards the MSB with the XOR of
// the tapped bits entering at bit 0. Never holds zero when seeded nonzero.
//   CLK     clock, rising edge
//   INIT_N  asynchronous active-low reset, loads SEED
//   EN      advance one step this cycle
//   Q       current LFSR state, WIDTH bits
// ---------------------------------------------------------------------------
module stoch_lfsr
    import stoch_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             CLK,
    input  logic             INIT_N,
    input  logic             EN,
    output logic [WIDTH-1:0] Q
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS8);

    logic feedback;

    assign feedback = ^(Q & TAPS);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            Q <= SEED;
        end else if (EN) begin
            Q <= {Q[WIDTH-2:0], feedback};
        end
    end
endmodule

// File: rtl/stoch_bitgen3.sv
// ---------------------------------------------------------------------------
// stoch_bitgen3
// Binary-to-stochastic converter: on an accepted LOAD it latches a
// probability word and a length, then emits Len cycles of three independent
// stochastic bits whose ones-density is P_eff / (2^Psize - 1).
//   CLK     clock, rising edge
//   INIT_N  asynchronous active-low reset; aborts a burst without DONE
//   bus     stoch_bitgen3_if.slave: LOAD, ProbIN, Len in;
//           BitOUT, VALID, BUSY, DONE out (all registered)
// Build option: define STOCH_BIPOLAR_EN to treat ProbIN as two's complement
// (P_eff = ProbIN ^ 2^(Psize-1)); otherwise ProbIN is an unsigned probability.
// ---------------------------------------------------------------------------
module stoch_bitgen3
    import stoch_pkg::*;
#(
    parameter int               Psize = 8,
    parameter int               Lsize = 10,
    parameter logic [Psize-1:0] SEED0 = SEED0_DEF,
    parameter logic [Psize-1:0] SEED1 = SEED1_DEF,
    parameter logic [Psize-1:0] SEED2 = SEED2_DEF
) (
    input logic            CLK,
    input logic            INIT_N,
    stoch_bitgen3_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    logic [Psize-1:0] p_reg;
    logic [Psize-1:0] p_eff;
    logic [Lsize-1:0] l_reg;
    logic [Lsize-1:0] cnt;
    logic [Psize-1:0] lfsr_q [3];
    logic [2:0]       bit_out;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             run;
    logic             last_bit;

    assign run      = (state == RUN);
    assign last_bit = (cnt == l_reg - Lsize'(1));

`ifdef STOCH_BIPOLAR_EN
    // Offset binary: flipping the sign bit maps -2^(Psize-1) to 0.
    assign p_eff = p_reg ^ (Psize'(1) << (Psize - 1));
`else
    assign p_eff = p_reg;
`endif

    stoch_lfsr #(.WIDTH(Psize), .SEED(SEED0)) u_lfsr0 (
        .CLK(CLK), .INIT_N(INIT_N), .EN(run), .Q(lfsr_q[0])
    );
    stoch_lfsr #(.WIDTH(Psize), .SEED(SEED1)) u_lfsr1 (
        .CLK(CLK), .INIT_N(INIT_N), .EN(run), .Q(lfsr_q[1])
    );
    stoch_lfsr #(.WIDTH(Psize), .SEED(SEED2)) u_lfsr2 (
        .CLK(CLK), .INIT_N(INIT_N), .EN(run), .Q(lfsr_q[2])
    );

    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.LOAD) state_nxt = (bus.Len == '0) ? DONE : RUN;
            RUN:  if (last_bit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the pre-edge state, so VALID/BUSY/DONE lag
    // the FSM by one edge: DONE pulses while the FSM is already back in IDLE.
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            p_reg   <= '0;
            l_reg   <= '0;
            cnt     <= '0;
            bit_out <= 3'b000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.LOAD) begin
                p_reg <= bus.ProbIN;
                l_reg <= bus.Len;
                cnt   <= '0;
            end else if (run) begin
                cnt <= cnt + Lsize'(1);
            end
            // Compare against the pre-step LFSR value; over a full period of
            // 2^Psize-1 steps exactly P_eff values satisfy lfsr <= P_eff.
            for (int k = 0; k < 3; k++) begin
                bit_out[k] <= run && (lfsr_q[k] <= p_eff);
            end
            valid_q <= run;
            busy_q  <= (state != IDLE);
            done_q  <= (state == DONE);
        end
    end

    assign bus.BitOUT = bit_out;
    assign bus.VALID  = valid_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
endmodule

// File: tb/tb_stoch_bitgen3.sv
// ---------------------------------------------------------------------------
// tb_stoch_bitgen3
// Self-checking bench for stoch_bitgen3. A reference model built from the
// LFSR's full period (each stream is a walk through the same 255-entry
// orbit, starting at its seed's position) predicts every emitted bit
// triple and the DONE cycle; a monitor pops and compares on each VALID/DONE.
// Honours STOCH_BIPOLAR_EN in the model's P_eff.
// ---------------------------------------------------------------------------
module tb_stoch_bitgen3;
    localparam int PS = 8;
    localparam int LS = 10;
    localparam int PERIOD = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    stoch_bitgen3_if #(.Psize(PS), .Lsize(LS)) bus ();

    stoch_bitgen3 #(.Psize(PS), .Lsize(LS)) dut (
        .CLK(clk), .INIT_N(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] orbit [PERIOD];
    int         pos   [3];
    logic [2:0] exp_q [$];
    int         done_q [$];

    function automatic logic [7:0] poly_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int orbit_index(input logic [7:0] v);
        for (int i = 0; i < PERIOD; i++) if (orbit[i] == v) return i;
        return 0;
    endfunction

    function automatic logic [7:0] peff_of(input logic [7:0] p);
`ifdef STOCH_BIPOLAR_EN
        return p ^ 8'h80;
`else
        return p;
`endif
    endfunction

    task automatic model_reset();
        pos[0] = orbit_index(8'h01);
        pos[1] = orbit_index(8'h5A);
        pos[2] = orbit_index(8'hC3);
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic model_burst(input logic [7:0] p, input int len, input int done_cyc);
        logic [2:0] e;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 3; k++) begin
                e[k] = (orbit[pos[k]] <= peff_of(p));
                pos[k] = (pos[k] + 1) % PERIOD;
            end
            exp_q.push_back(e);
        end
        done_q.push_back(done_cyc);
    endtask

    // ---------------- monitor ----------------
    int         ones [3] = '{0, 0, 0};
    logic [254:0] sh [3];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.VALID) begin
                if (exp_q.size() == 0) begin
                    check("valid_without_expect", bus.VALID, 1'b0);
                end else begin
                    check("bitout", bus.BitOUT, exp_q.pop_front());
                end
                for (int k = 0; k < 3; k++) begin
                    ones[k] += bus.BitOUT[k];
                    sh[k] = {sh[k][253:0], bus.BitOUT[k]};
                end
            end else begin
                check("bitout_zero_when_invalid", bus.BitOUT, 3'b000);
            end
            if (bus.DONE) begin
                if (done_q.size() == 0) check("unexpected_done", bus.DONE, 1'b0);
                else                    check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic burst(input logic [7:0] p, input int len, input bit ign);
        @(negedge clk);
        bus.LOAD   = 1'b1;
        bus.ProbIN = p;
        bus.Len    = LS'(len);
        model_burst(p, len, cyc + len + 2);
        @(posedge clk);
        #1 bus.LOAD = 1'b0;
        if (ign) begin
            repeat (3) @(negedge clk);
            bus.LOAD   = 1'b1;
            bus.ProbIN = ~p;
            bus.Len    = LS'(3);
            @(negedge clk);
            bus.LOAD = 1'b0;
        end
        for (int i = 0; i < len + 10 && !bus.DONE; i++) @(negedge clk);
        check("done_seen", bus.DONE, 1'b1);
    endtask

    int ones0 [3];

    initial begin
        logic [7:0] s;
        s = 8'h01;
        for (int i = 0; i < PERIOD; i++) begin
            orbit[i] = s;
            s = poly_next(s);
        end
        model_reset();
        bus.LOAD = 1'b0; bus.ProbIN = '0; bus.Len = '0;

        // Reset then idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_outputs", {bus.BitOUT, bus.VALID, bus.BUSY, bus.DONE}, 6'd0);
        end

        // Density over one full LFSR period from reset seeds
        ones0 = ones;
        burst(8'd64, 255, 1'b0);
        for (int k = 0; k < 3; k++)
            check($sformatf("density_ones_%0d", k), ones[k] - ones0[k], peff_of(8'd64));
        check("streams_differ_01", (sh[0] == sh[1]), 1'b0);
        check("streams_differ_12", (sh[1] == sh[2]), 1'b0);

        // Extremes and length boundaries
        burst(8'd0, 16, 1'b0);
        burst(8'd255, 16, 1'b0);
        burst(8'h80, 12, 1'b0);
        burst(8'h7F, 12, 1'b0);
        burst(8'd77, 0, 1'b0);
        burst(8'd200, 1, 1'b0);

        // LOAD during a burst is ignored
        burst(8'd100, 20, 1'b1);

        // Randomized bursts
        for (int i = 0; i < 8; i++) begin
            int len;
            len = $urandom_range(0, 40);
            burst(8'($urandom), len, (len > 8) && $urandom_range(0, 1) == 1);
        end

        // Abort mid-burst: outputs clear asynchronously, LFSRs restart
        @(negedge clk);
        bus.LOAD = 1'b1; bus.ProbIN = 8'd150; bus.Len = LS'(100);
        model_burst(8'd150, 100, 0);
        @(posedge clk);
        #1 bus.LOAD = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", {bus.BitOUT, bus.VALID, bus.BUSY, bus.DONE}, 6'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_idle", {bus.BitOUT, bus.VALID, bus.BUSY, bus.DONE}, 6'd0);
        end
        burst(8'd128, 10, 1'b0);
        repeat (3) @(negedge clk);

        check("expect_queue_drained", exp_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
